// File: rtl/mem_page_slave.sv
//-----------------------------------------------------------------------------
// mem_page_slave
//
// Memory-side slave on the shared address/data bus. It watches address phases
// for its own page, then serves a fixed-length data burst out of (or into) one
// page of word storage. There are no wait states and no acknowledge. A burst
// is always one address cycle followed by exactly BURST_LEN data cycles.
//
// Optional feature (compile-time macro):
//   MEM_PAGE_SLAVE_ERR_EN  when defined, err is a sticky protocol-error flag.
//                          It sets when AddrValid is seen during a data beat.
//                          In simulation it also sets when an address phase
//                          carries X/Z page bits. Only reset clears it.
//                          When undefined, err is tied to 0 and no error
//                          logic is built.
//
// Ports:
//   clk        in     1       bus clock; all state changes on posedge
//   resetL     in     1       asynchronous, active-low reset
//   AddrValid  in     1       master: AddrData holds an address this cycle
//   rw         in     1       master: 1 = read, 0 = write (address cycle only)
//   AddrData   inout  DATA_W  shared address/data bus; the slave drives it
//                             only during read beats, otherwise 'z
//   busy       out    1       1 while a burst is in progress
//   err        out    1       sticky protocol error (see macro above)
//   state_dbg  out    1       FSM state (0 = IDLE, 1 = BEAT) for checkers
//   rd_oe      out    1       1 while the slave drives AddrData
//
// Handshake: there is no valid/ready pair on this bus.
//   - The master asserts AddrValid for one cycle with {page, offset} on
//     AddrData. If the page matches, that cycle is the accept.
//   - The next BURST_LEN cycles are data beats. On write beats the master
//     drives data. On read beats the slave drives data, combinationally,
//     for the whole cycle.
//   - No beat can be stalled.
//-----------------------------------------------------------------------------
`default_nettype none

module mem_page_slave #(
   parameter int                DATA_W    = 16,
   parameter int                PAGE_W    = 4,
   parameter int                ADDR_W    = 12,
   parameter logic [PAGE_W-1:0] PAGE_ID   = 4'h2,
   parameter int                BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              resetL,
   input  logic              AddrValid,
   input  logic              rw,
   inout  wire  [DATA_W-1:0] AddrData,
   output logic              busy,
   output logic              err,
   output logic              state_dbg,
   output logic              rd_oe
);

   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BEAT = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic [ADDR_W-1:0]   base_q,  base_d;
   logic                rw_q,    rw_d;

   logic [DATA_W-1:0]   mem [0:DEPTH-1];

   logic [PAGE_W-1:0]   bus_page;
   logic [ADDR_W-1:0]   bus_offset;
   logic                addr_hit;
   logic [ADDR_W-1:0]   ptr;
   logic                wr_en;
   logic [DATA_W-1:0]   rd_data;

   // The address phase splits into {page, offset}.
   // The page occupies the top PAGE_W bits of the bus.
   assign bus_page   = AddrData[DATA_W-1 -: PAGE_W];
   assign bus_offset = AddrData[ADDR_W-1:0];

   // An address is only recognised in IDLE.
   // During beats, AddrValid is treated as noise on a data cycle.
   assign addr_hit = (state_q == IDLE) && AddrValid && (bus_page == PAGE_ID);

   // The word pointer wraps inside the page.
   // The ADDR_W-bit add drops the carry, so 0xFFF + 1 lands on 0x000.
   assign ptr = base_q + ADDR_W'(cnt_q);

   //--------------------------------------------------------------------------
   // FSM: next state and burst bookkeeping
   //--------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      rw_d    = rw_q;
      case (state_q)
         IDLE: begin
            if (addr_hit) begin
               state_d = BEAT;
               cnt_d   = '0;
               base_d  = bus_offset;
               // Direction is fixed here.
               // The master may change rw freely during the beats.
               rw_d    = rw;
            end
         end
         BEAT: begin
            if (cnt_q == LAST_BEAT) begin
               // Returning straight to IDLE lets the very next cycle be a
               // new address phase.
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetL) begin
      if (!resetL) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         rw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         rw_q    <= rw_d;
      end
   end

   //--------------------------------------------------------------------------
   // Storage
   // Reset does not clear the storage.
   // Reset forces state_q to IDLE asynchronously. That alone blocks further
   // writes once reset lands mid-burst. Beats already written are kept.
   //--------------------------------------------------------------------------
   assign wr_en = (state_q == BEAT) && !rw_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[ptr] <= AddrData;
      end
   end

   // Read data is combinational off the pointer.
   // It is therefore valid within the beat cycle, in time for a
   // mid-cycle sample.
   assign rd_data = mem[ptr];
   assign rd_oe   = (state_q == BEAT) && rw_q;
   assign AddrData = rd_oe ? rd_data : {DATA_W{1'bz}};

   assign busy      = (state_q != IDLE);
   assign state_dbg = state_q;

   //--------------------------------------------------------------------------
   // Protocol error flag
   //--------------------------------------------------------------------------
`ifdef MEM_PAGE_SLAVE_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      // An address strobe in the middle of a burst is a master bug.
      // The burst itself carries on untouched.
      if ((state_q == BEAT) && AddrValid) begin
         err_d = 1'b1;
      end
      // An unknown page in an address phase can only be seen in simulation.
      // Synthesis evaluates $isunknown as 0.
      if ((state_q == IDLE) && AddrValid && $isunknown(bus_page)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetL) begin
      if (!resetL) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_page_slave.sv
//-----------------------------------------------------------------------------
// tb_mem_page_slave
//
// Directed bench for mem_page_slave.
// - A table of burst records is applied in one loop.
// - Hand-written sequences cover: reset mid-burst, back-to-back write->read
//   with rw dropped during the read beats, and AddrValid inside a burst.
// - Inputs change 1 time unit after posedge.
// - Outputs are sampled on negedge.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_page_slave;

   localparam int DATA_W = 16;

   //--------------------------------------------------------------------------
   // Clock / reset
   //--------------------------------------------------------------------------
   logic clk = 1'b0;
   logic resetL = 1'b0;
   always #5 clk = ~clk;

   //--------------------------------------------------------------------------
   // Master side of the shared bus
   //--------------------------------------------------------------------------
   logic              m_av    = 1'b0;
   logic              m_rw    = 1'b0;
   logic              m_drive = 1'b0;
   logic [DATA_W-1:0] m_data  = '0;

   wire  [DATA_W-1:0] addr_data;
   logic              busy;
   logic              err;
   logic              state_dbg;
   logic              rd_oe;

   assign addr_data = m_drive ? m_data : {DATA_W{1'bz}};

   mem_page_slave dut (
      .clk       (clk),
      .resetL    (resetL),
      .AddrValid (m_av),
      .rw        (m_rw),
      .AddrData  (addr_data),
      .busy      (busy),
      .err       (err),
      .state_dbg (state_dbg),
      .rd_oe     (rd_oe)
   );

`ifdef MEM_PAGE_SLAVE_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   //--------------------------------------------------------------------------
   // Scoreboard counters and compare helper
   //--------------------------------------------------------------------------
   int   n_checks = 0;
   int   n_errors = 0;
   logic err_model = 1'b0;

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   //--------------------------------------------------------------------------
   // Driver tasks
   //--------------------------------------------------------------------------

   // One complete burst: an address cycle followed by 4 beats.
   // - On return, the next cycle is free for another address phase.
   // - hit   : whether the page is expected to match.
   // - data  : beat 0 in the top 16 bits. It is write data for writes and
   //           expected bus data for reads.
   // - rw_bt : value put on rw during the beats.
   // - av_bt : beat index where AddrValid is raised (-1 = none).
   task automatic burst(input string tag, input logic [15:0] addr,
                        input logic rw_a, input logic hit,
                        input logic [63:0] data, input logic rw_bt,
                        input int av_bt);
      m_av    = 1'b1;
      m_rw    = rw_a;
      m_drive = 1'b1;
      m_data  = addr;
      @(negedge clk);
      check({tag, " addr busy"}, 16'(busy), 16'(0));
      @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++) begin
         m_av    = (b == av_bt);
         m_rw    = rw_bt;
         m_drive = !rw_a || !hit;
         m_data  = rw_a ? 16'h0000 : data[63 - 16*b -: 16];
         @(negedge clk);
         check($sformatf("%s b%0d busy", tag, b), 16'(busy), 16'(hit));
         check($sformatf("%s b%0d oe", tag, b), 16'(rd_oe), 16'(hit && rw_a));
         check($sformatf("%s b%0d err", tag, b), 16'(err), 16'(err_model));
         if (hit && rw_a)
            check($sformatf("%s b%0d data", tag, b), addr_data,
                  data[63 - 16*b -: 16]);
         @(posedge clk);
         #1;
         if ((b == av_bt) && hit && ERR_EN) err_model = 1'b1;
      end
      m_av    = 1'b0;
      m_rw    = 1'b0;
      m_drive = 1'b0;
   endtask

   task automatic idle_cycle(input string tag);
      m_av    = 1'b0;
      m_drive = 1'b0;
      @(negedge clk);
      check({tag, " idle busy"}, 16'(busy), 16'(0));
      check({tag, " idle oe"}, 16'(rd_oe), 16'(0));
      check({tag, " idle err"}, 16'(err), 16'(err_model));
      @(posedge clk);
      #1;
   endtask

   //--------------------------------------------------------------------------
   // Stimulus table
   //--------------------------------------------------------------------------
   typedef struct packed {
      logic [15:0] addr;
      logic        rw;
      logic        hit;
      logic [63:0] data;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   //--------------------------------------------------------------------------
   // Test sequence
   //--------------------------------------------------------------------------
   initial begin
      // Preload 0x002..0x005. The wrap test reads 0x002/0x003 back later.
      vecs[0] = '{16'h2002, 1'b0, 1'b1, 64'haaaa_bbbb_cccc_dddd};
      vecs[1] = '{16'h2004, 1'b0, 1'b1, 64'h1234_5678_9abc_4314};
      vecs[2] = '{16'h2004, 1'b1, 1'b1, 64'h1234_5678_9abc_4314};
      // Page 3 is somebody else's: no capture, no drive.
      vecs[3] = '{16'h3004, 1'b0, 1'b0, 64'hdead_dead_dead_dead};
      vecs[4] = '{16'h3004, 1'b1, 1'b0, 64'h0};
      vecs[5] = '{16'h2004, 1'b1, 1'b1, 64'h1234_5678_9abc_4314};
      // Offset wrap inside the page: FFE, FFF, 000, 001.
      vecs[6] = '{16'h2ffe, 1'b0, 1'b1, 64'h0071_0034_0078_00bc};
      vecs[7] = '{16'h2ffe, 1'b1, 1'b1, 64'h0071_0034_0078_00bc};
      vecs[8] = '{16'h2000, 1'b1, 1'b1, 64'h0078_00bc_aaaa_bbbb};
      // Known contents for the reset-mid-burst test.
      vecs[9] = '{16'h2010, 1'b0, 1'b1, 64'h1111_2222_3333_4444};

      // Reset state
      #2;
      check("rst busy", 16'(busy), 16'(0));
      check("rst err", 16'(err), 16'(0));
      check("rst oe", 16'(rd_oe), 16'(0));
      check("rst state", 16'(state_dbg), 16'(0));
      @(negedge clk);
      resetL = 1'b1;
      @(posedge clk);
      #1;
      idle_cycle("post_rst");

      // Table-driven bursts, issued back-to-back
      for (int i = 0; i < NV; i++) begin
         burst($sformatf("v%0d", i), vecs[i].addr, vecs[i].rw, vecs[i].hit,
               vecs[i].data, vecs[i].rw, -1);
      end
      idle_cycle("table");

      // Reset during beat 1 of a write to 0x010.
      // - Beat 0 lands (f671).
      // - Everything after is dropped.
      m_av = 1'b1; m_rw = 1'b0; m_drive = 1'b1; m_data = 16'h2010;
      @(posedge clk);
      #1;
      m_av = 1'b0; m_data = 16'hf671;
      @(negedge clk);
      check("rstmid b0 busy", 16'(busy), 16'(1));
      @(posedge clk);
      #1;
      m_data = 16'h1234;
      @(negedge clk);
      check("rstmid b1 busy", 16'(busy), 16'(1));
      #1;
      resetL = 1'b0;
      #1;
      check("rstmid busy", 16'(busy), 16'(0));
      check("rstmid oe", 16'(rd_oe), 16'(0));
      check("rstmid state", 16'(state_dbg), 16'(0));
      err_model = 1'b0;
      @(posedge clk);
      #1;
      m_data = 16'h5678;
      @(posedge clk);
      #1;
      m_drive = 1'b0;
      resetL  = 1'b1;
      idle_cycle("rstmid");
      burst("rstmid rd", 16'h2010, 1'b1, 1'b1, 64'hf671_2222_3333_4444, 1'b1, -1);

      // Write, then a read address in the very next cycle.
      // rw is held at 0 during the read beats.
      burst("b2b wr", 16'h2020, 1'b0, 1'b1, 64'h0102_0304_0506_0708, 1'b0, -1);
      burst("b2b rd", 16'h2020, 1'b1, 1'b1, 64'h0102_0304_0506_0708, 1'b0, -1);
      idle_cycle("b2b");

      // AddrValid during beat 2.
      // - The beat value looks like a page-2 address; it must still be
      //   stored as data.
      // - err follows the build option.
      burst("av wr", 16'h2030, 1'b0, 1'b1, 64'hc0de_beef_2040_f00d, 1'b0, 2);
      idle_cycle("av");
      burst("av rd", 16'h2030, 1'b1, 1'b1, 64'hc0de_beef_2040_f00d, 1'b1, -1);
      idle_cycle("end");
      check("final err", 16'(err), 16'(ERR_EN));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Safety net against a runaway run
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit 200000 ns");
      $fatal(1, "timeout");
   end

endmodule
